barrel_multiplier: RTL and testbench



---
 rtl/barrel_multiplier_pkg.sv | 22 ++
 rtl/shift_stage.sv | 61 ++++++
 rtl/barrel_multiplier.sv | 76 +++++++
 tb/tb_barrel_multiplier.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_multiplier_pkg.sv
// Shared constants and constant functions for the barrel multiplier pipeline.
// Saturation bounds are returned as 64-bit values; callers truncate them to WIDTH.
package barrel_multiplier_pkg;

   function automatic longint sat_max(input int width);
      return (longint'(1) <<< (width - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

   function automatic int stage_count(input int shift_w);
      return shift_w;
   endfunction

   // A step of 2^stage positions that is at least the word width pushes every bit out.
   function automatic bit step_clears_word(input int stage, input int width);
      return (longint'(1) <<< stage) >= longint'(width);
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered pipeline step: conditionally shifts left by 2^STAGE and
// accumulates a sticky overflow flag against the operand's original sign.
module shift_stage
   import barrel_multiplier_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHIFT_W = 4,
   parameter int STAGE   = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHIFT_W-1:0] in_shift,
   input  logic               in_ovf,
   input  logic               in_sign,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SHIFT_W-1:0] out_shift,
   output logic               out_ovf,
   output logic               out_sign
);

   logic [WIDTH-1:0] shifted;
   logic             overflow;

   if (step_clears_word(STAGE, WIDTH)) begin : g_flush
      always_comb begin
         shifted  = '0;
         overflow = |in_data;
      end
   end else begin : g_shift
      localparam int STEP = 1 << STAGE;
      // Every bit shifted out, plus the new sign bit, must match the original sign.
      always_comb begin
         shifted  = in_data << STEP;
         overflow = in_data[WIDTH-1 -: STEP+1] != {(STEP+1){in_sign}};
      end
   end

   // Bubbles only clear the valid bit; the payload keeps its last real value.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_shift <= '0;
         out_ovf   <= 1'b0;
         out_sign  <= 1'b0;
      end else if (en) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data  <= in_shift[STAGE] ? shifted : in_data;
            out_shift <= in_shift;
            out_ovf   <= in_ovf | (in_shift[STAGE] & overflow);
            out_sign  <= in_sign;
         end
      end
   end

endmodule

// File: rtl/barrel_multiplier.sv
// Pipelined saturating y = x * 2^shift_n: one shift_stage per shift_n bit,
// a global stall when the consumer back-pressures, and saturation on the last stage.
module barrel_multiplier
   import barrel_multiplier_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHIFT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x,
   input  logic [SHIFT_W-1:0] shift_n,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   y,
   output logic               ovf
);

   localparam int               STAGES  = stage_count(SHIFT_W);
   localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

   logic               stall;
   logic               advance;
   logic               valid_pipe [0:STAGES];
   logic [WIDTH-1:0]   data_pipe  [0:STAGES];
   logic [SHIFT_W-1:0] shift_pipe [0:STAGES];
   logic               ovf_pipe   [0:STAGES];
   logic               sign_pipe  [0:STAGES];

   assign stall    = out_valid & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = ~stall;

   assign valid_pipe[0] = in_valid;
   assign data_pipe[0]  = x;
   assign shift_pipe[0] = shift_n;
   assign ovf_pipe[0]   = 1'b0;
   assign sign_pipe[0]  = x[WIDTH-1];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      shift_stage #(
         .WIDTH   (WIDTH),
         .SHIFT_W (SHIFT_W),
         .STAGE   (k)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .en        (advance),
         .in_valid  (valid_pipe[k]),
         .in_data   (data_pipe[k]),
         .in_shift  (shift_pipe[k]),
         .in_ovf    (ovf_pipe[k]),
         .in_sign   (sign_pipe[k]),
         .out_valid (valid_pipe[k+1]),
         .out_data  (data_pipe[k+1]),
         .out_shift (shift_pipe[k+1]),
         .out_ovf   (ovf_pipe[k+1]),
         .out_sign  (sign_pipe[k+1])
      );
   end

   assign out_valid = valid_pipe[STAGES];

   // The last stage register is the output register; saturation is a mux on it.
   always_comb begin
      ovf = ovf_pipe[STAGES];
      y   = data_pipe[STAGES];
      if (ovf_pipe[STAGES]) begin
         y = sign_pipe[STAGES] ? SAT_MIN : SAT_MAX;
      end
   end

endmodule

// File: tb/tb_barrel_multiplier.sv
// Self-checking bench for barrel_multiplier: directed table, back-pressure,
// mid-stream reset and randomized traffic against an arithmetic reference.
module tb_barrel_multiplier;

   localparam int WIDTH   = 8;
   localparam int SHIFT_W = 4;
   localparam longint MAXV = (longint'(1) <<< (WIDTH - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (WIDTH - 1));

   typedef struct {
      logic [WIDTH-1:0]   y;
      logic               ovf;
      logic [WIDTH-1:0]   x;
      logic [SHIFT_W-1:0] n;
      int                 acc_cyc;
      int                 acc_stalls;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [WIDTH-1:0]   x = '0;
   logic [SHIFT_W-1:0] shift_n = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [WIDTH-1:0]   y;
   logic               ovf;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   stalls = 0;
   bit   was_stalled = 0;
   logic [WIDTH-1:0] held_y;
   logic             held_ovf;
   exp_t sb [$];

   barrel_multiplier #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .shift_n   (shift_n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Exact product in wide arithmetic, then clamp to the signed range.
   function automatic void refModel(input logic [WIDTH-1:0] xv, input logic [SHIFT_W-1:0] n,
                                    output logic [WIDTH-1:0] ye, output logic oe);
      longint p;
      p = longint'($signed(xv)) * (longint'(1) <<< n);
      oe = 1'b1;
      if (p > MAXV)      ye = WIDTH'(MAXV);
      else if (p < MINV) ye = WIDTH'(MINV);
      else begin
         ye = WIDTH'(p);
         oe = 1'b0;
      end
   endfunction

   // One clock cycle: drive at negedge, sample 1 time unit later, then wait for the next negedge.
   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] xv, input logic [SHIFT_W-1:0] n,
                                input logic ordy, input bit has_exp, input logic [WIDTH-1:0] exp_y,
                                input logic exp_ovf, output bit accepted);
      exp_t e;
      int   ys;
      in_valid = v; x = xv; shift_n = n; out_ready = ordy;
      #1;
      if (out_valid && !out_ready) begin
         checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
         if (was_stalled) begin
            checkOutput("stall_y_hold", 32'(y), 32'(held_y));
            checkOutput("stall_ovf_hold", 32'(ovf), 32'(held_ovf));
         end else begin
            held_y = y;
            held_ovf = ovf;
         end
         stalls++;
         was_stalled = 1;
      end else begin
         checkOutput("in_ready", 32'(in_ready), 32'd1);
         was_stalled = 0;
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_out", 32'(y), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            checkOutput("y", 32'(y), 32'(e.y));
            checkOutput("ovf", 32'(ovf), 32'(e.ovf));
            if (e.acc_stalls == stalls) checkOutput("latency", 32'(cyc - e.acc_cyc), 32'(SHIFT_W));
            if (!ovf) begin
               ys = int'($signed(y));
               checkOutput("roundtrip", 32'(ys >>> e.n), 32'(int'($signed(e.x))));
            end
         end
      end
      accepted = v && in_ready;
      if (accepted) begin
         e.x = xv; e.n = n; e.acc_cyc = cyc; e.acc_stalls = stalls;
         if (has_exp) begin
            e.y = exp_y; e.ovf = exp_ovf;
         end else begin
            refModel(xv, n, e.y, e.ovf);
         end
         sb.push_back(e);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic driveDirected(input logic [WIDTH-1:0] xv, input logic [SHIFT_W-1:0] n,
                                input logic [WIDTH-1:0] ey, input logic eo);
      bit acc;
      acc = 0;
      for (int t = 0; t < 20 && !acc; t++) applyStimulus(1'b1, xv, n, 1'b1, 1'b1, ey, eo, acc);
      if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      bit acc;
      for (int t = 0; t < 60 && sb.size() != 0; t++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, acc);
      if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic doReset(input int n);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (n) begin
         @(negedge clk);
         cyc++;
      end
      rst = 1'b0;
      sb.delete();
      was_stalled = 0;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_y", 32'(y), 32'd0);
      checkOutput("rst_ovf", 32'(ovf), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      bit acc;
      int idx;
      int hold;
      bit hold_started;
      int accepted_cnt;
      logic [WIDTH-1:0]   bx [0:5];
      logic [SHIFT_W-1:0] bn [0:5];

      doReset(2);

      // Directed vectors with hand-derived results.
      driveDirected(8'hE9, 4'd0, 8'hE9, 1'b0);
      driveDirected(8'hE9, 4'd1, 8'hD2, 1'b0);
      driveDirected(8'hE9, 4'd2, 8'hA4, 1'b0);
      driveDirected(8'hE9, 4'd3, 8'h80, 1'b1);
      driveDirected(8'h17, 4'd0, 8'h17, 1'b0);
      driveDirected(8'h17, 4'd1, 8'h2E, 1'b0);
      driveDirected(8'h17, 4'd2, 8'h5C, 1'b0);
      for (int n = 3; n < 8; n++) driveDirected(8'h17, 4'(n), 8'h7F, 1'b1);
      driveDirected(8'h00, 4'd15, 8'h00, 1'b0);
      driveDirected(8'hFF, 4'd7, 8'h80, 1'b0);
      driveDirected(8'h80, 4'd1, 8'h80, 1'b1);
      driveDirected(8'h40, 4'd1, 8'h7F, 1'b1);
      drain();

      // Back-pressure: six items, consumer stalls five cycles once out_valid rises.
      for (int i = 0; i < 6; i++) begin
         bx[i] = WIDTH'($urandom);
         bn[i] = SHIFT_W'($urandom_range(0, 3));
      end
      idx = 0; hold = 0; hold_started = 0;
      for (int t = 0; t < 60 && (idx < 6 || sb.size() != 0); t++) begin
         if (out_valid && !hold_started) begin
            hold_started = 1;
            hold = 5;
         end
         applyStimulus(idx < 6, bx[idx % 6], bn[idx % 6], hold == 0, 1'b0, '0, 1'b0, acc);
         if (hold > 0) hold--;
         if (acc) idx++;
      end
      checkOutput("bp_all_sent", 32'(idx), 32'd6);
      checkOutput("bp_all_out", 32'(sb.size()), 32'd0);

      // Reset with three items in flight; none of them may ever emerge.
      driveDirected(8'h05, 4'd1, 8'h0A, 1'b0);
      driveDirected(8'h06, 4'd1, 8'h0C, 1'b0);
      driveDirected(8'h07, 4'd1, 8'h0E, 1'b0);
      doReset(1);
      for (int t = 0; t < 6; t++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, acc);
      driveDirected(8'h11, 4'd1, 8'h22, 1'b0);
      drain();

      // Randomized traffic with random bubbles and back-pressure.
      accepted_cnt = 0;
      for (int t = 0; t < 6000 && accepted_cnt < 1000; t++) begin
         applyStimulus($urandom_range(0, 9) < 8, WIDTH'($urandom), SHIFT_W'($urandom),
                       $urandom_range(0, 3) != 0, 1'b0, '0, 1'b0, acc);
         if (acc) accepted_cnt++;
      end
      checkOutput("rand_accepted", 32'(accepted_cnt), 32'd1000);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
